// File: rtl/mmstage_ctrl.sv
// Memory-stage data-cache access controller: issues the cache strobes, stalls the pipe while an access is outstanding.
// Optional LL/SC link tracking is built when MMCTRL_LLSC_EN is defined.
module mmstage_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dRENi,
    input  logic        dWENi,
    input  logic [31:0] ALUOut,
    input  logic [31:0] store,
    input  logic        halt,
    input  logic        llop,
    input  logic        scop,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    input  logic        ext_stall,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] loaddata,
    output logic        pipe_en,
    output logic        halted,
    output logic [1:0]  o_dbg_state
);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    word_t  r_cap;
    logic   r_halted;

    logic   w_req;
    logic   w_sc_fail;
    logic   w_access;
    logic   w_pipe_en;
    logic   w_done;
    logic   w_wr_sel;
    logic   w_rd_sel;
    word_t  w_result;
    logic   w_unused;

    assign w_req = (dRENi | dWENi) & ~r_halted;

`ifdef MMCTRL_LLSC_EN
    logic        r_link_valid;
    logic [29:0] r_link_addr;
    logic        w_link_hit;
    logic        w_sc_ok;
    logic        w_ll_set;
    logic        w_st_clr;
    logic        w_snp_clr;
    logic [29:0] w_link_addr_nxt;

    assign w_link_hit = r_link_valid & (r_link_addr == ALUOut[31:2]);
    // A failing SC never reaches the cache; once in WAIT the write was already committed.
    assign w_sc_fail  = scop & ~w_link_hit & (r_state == S_IDLE);
    assign w_sc_ok    = (r_state == S_WAIT) | w_link_hit;
    assign w_result   = scop ? {31'd0, w_sc_ok} : dmemload;

    assign w_ll_set        = w_done & llop & dRENi & ~dWENi;
    assign w_st_clr        = w_done & dWENi & w_link_hit;
    assign w_link_addr_nxt = w_ll_set ? ALUOut[31:2] : r_link_addr;
    // Compared against the post-update address so a same-cycle invalidate kills a fresh LL.
    assign w_snp_clr       = snoop_inv & (snoop_addr[31:2] == w_link_addr_nxt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= 30'd0;
        end else begin
            if (w_snp_clr)
                r_link_valid <= 1'b0;
            else if (w_ll_set)
                r_link_valid <= 1'b1;
            else if (w_st_clr)
                r_link_valid <= 1'b0;
            r_link_addr <= w_link_addr_nxt;
        end
    end

    assign w_unused = ^{ALUOut[1:0], snoop_addr[1:0]};
`else
    assign w_sc_fail = 1'b0;
    assign w_result  = dmemload;
    assign w_unused  = ^{llop, scop, snoop_inv, snoop_addr, ALUOut[1:0]};
`endif

    always_comb begin
        w_access  = 1'b0;
        w_pipe_en = ~ext_stall;
        case (r_state)
            S_IDLE: begin
                w_access = w_req & ~w_sc_fail;
                if (w_access)
                    w_pipe_en = dhit & ~ext_stall;
            end
            S_WAIT: begin
                w_access  = w_req;
                w_pipe_en = dhit & ~ext_stall;
            end
            default: begin
                w_access  = 1'b0;
                w_pipe_en = ~ext_stall;
            end
        endcase
    end

    assign w_done   = w_access & dhit;
    assign w_wr_sel = w_access & dWENi;
    assign w_rd_sel = w_access & dRENi & ~dWENi;

    // Strobes are gated by reset directly so the cache sees the request vanish at once.
    assign dmemWEN     = w_wr_sel & nRST;
    assign dmemREN     = w_rd_sel & nRST;
    assign dmemaddr    = {ALUOut[31:2], 2'b00};
    assign dmemstore   = store;
    assign loaddata    = (r_state == S_DONE) ? r_cap : w_result;
    assign pipe_en     = w_pipe_en;
    assign halted      = r_halted;
    assign o_dbg_state = r_state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_cap    <= '0;
            r_halted <= 1'b0;
        end else begin
            if (halt & w_pipe_en)
                r_halted <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (!dhit) begin
                            r_state <= S_WAIT;
                        end else if (ext_stall) begin
                            r_state <= S_DONE;
                            r_cap   <= w_result;
                        end
                    end
                end
                S_WAIT: begin
                    if (dhit) begin
                        if (ext_stall) begin
                            r_state <= S_DONE;
                            r_cap   <= w_result;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (!ext_stall)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmstage_ctrl.sv
// Directed bench for mmstage_ctrl: driver pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_mmstage_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dRENi, dWENi, halt, llop, scop, snoop_inv, ext_stall, dhit;
    logic [31:0] ALUOut, store, snoop_addr, dmemload;
    logic        dmemREN, dmemWEN, pipe_en, halted;
    logic [31:0] dmemaddr, dmemstore, loaddata;
    logic [1:0]  o_dbg_state;

    logic [99:0] exp_q[$];
    int          id_q[$];
    int          total = 0;
    int          bad = 0;
    int          step_no = 0;
    logic [99:0] got_v, exp_v;
    int          id_v;

    mmstage_ctrl dut (
        .CLK(CLK), .nRST(nRST), .dRENi(dRENi), .dWENi(dWENi), .ALUOut(ALUOut),
        .store(store), .halt(halt), .llop(llop), .scop(scop), .snoop_inv(snoop_inv),
        .snoop_addr(snoop_addr), .ext_stall(ext_stall), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .loaddata(loaddata), .pipe_en(pipe_en), .halted(halted), .o_dbg_state(o_dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] st);
        dRENi  = ren;
        dWENi  = wen;
        ALUOut = addr;
        store  = st;
    endtask

    // One clock of stimulus; the expected outputs for this cycle go to the scoreboard.
    task automatic step(input logic dh, input logic es, input logic [31:0] ml,
                        input logic e_ren, input logic e_wen, input logic e_pe,
                        input logic e_hlt, input logic [31:0] e_ld);
        dhit      = dh;
        ext_stall = es;
        dmemload  = ml;
        exp_q.push_back({e_ren, e_wen, e_pe, e_hlt, e_ld, ALUOut[31:2], 2'b00, store});
        id_q.push_back(step_no);
        step_no++;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            id_v  = id_q.pop_front();
            got_v = {dmemREN, dmemWEN, pipe_en, halted, loaddata, dmemaddr, dmemstore};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL step%0d {ren,wen,pe,hlt,ld,addr,st} got=%h exp=%h", id_v, got_v, exp_v);
            end
        end
    end

    initial begin
        nRST = 1'b0; halt = 1'b0; llop = 1'b0; scop = 1'b0; snoop_inv = 1'b0;
        snoop_addr = '0; dhit = 1'b0; ext_stall = 1'b0; dmemload = '0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;

        // reset state
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        nRST = 1'b1;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // load hit same cycle
        set_req(1, 0, 32'h100, 32'h0);
        step(1, 0, 32'hDEADBEEF, 1, 0, 1, 0, 32'hDEADBEEF);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // store miss, hit after 3 stall cycles; low address bits masked
        set_req(0, 1, 32'h207, 32'h12345678);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 1, 1, 0, 32'h0);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // load hit under external stall: captured data held, no re-issue, stray dhit in DONE ignored
        set_req(1, 0, 32'h300, 32'h0);
        step(1, 1, 32'hA5A5A5A5, 1, 0, 0, 0, 32'hA5A5A5A5);
        step(0, 1, 32'h11111111, 0, 0, 0, 0, 32'hA5A5A5A5);
        step(1, 0, 32'h22222222, 0, 0, 1, 0, 32'hA5A5A5A5);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // no request: stray dhit ignored, pipe_en follows ext_stall
        step(1, 0, 32'h33333333, 0, 0, 1, 0, 32'h33333333);
        step(0, 1, 32'h0, 0, 0, 0, 0, 32'h0);

        // load miss completing under ext_stall
        set_req(1, 0, 32'h400, 32'h0);
        step(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
        step(1, 1, 32'hCAFEF00D, 1, 0, 0, 0, 32'hCAFEF00D);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'hCAFEF00D);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // read and write both requested: write wins
        set_req(1, 1, 32'h500, 32'h55);
        step(1, 0, 32'h0, 0, 1, 1, 0, 32'h0);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

`ifndef MMCTRL_LLSC_EN
        // SC is a plain store, loaddata untouched
        scop = 1'b1;
        set_req(0, 1, 32'h40, 32'h99);
        step(1, 0, 32'h77, 0, 1, 1, 0, 32'h77);
        scop = 1'b0;
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
`else
        // LL then SC succeeds
        llop = 1'b1;
        set_req(1, 0, 32'h40, 32'h0);
        step(1, 0, 32'h5, 1, 0, 1, 0, 32'h5);
        llop = 1'b0; scop = 1'b1;
        set_req(0, 1, 32'h40, 32'h99);
        step(1, 0, 32'hABC, 0, 1, 1, 0, 32'h1);
        // link consumed: second SC fails without a strobe
        step(1, 0, 32'hABC, 0, 0, 1, 0, 32'h0);
        scop = 1'b0;
        // LL, remote invalidate, SC fails
        llop = 1'b1;
        set_req(1, 0, 32'h40, 32'h0);
        step(1, 0, 32'h6, 1, 0, 1, 0, 32'h6);
        llop = 1'b0;
        set_req(0, 0, 32'h0, 32'h0);
        snoop_inv = 1'b1; snoop_addr = 32'h43;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        snoop_inv = 1'b0; scop = 1'b1;
        set_req(0, 1, 32'h40, 32'h98);
        step(1, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        scop = 1'b0;
        // SC that misses the cache still returns 1, then link is gone
        llop = 1'b1;
        set_req(1, 0, 32'h80, 32'h0);
        step(1, 0, 32'h7, 1, 0, 1, 0, 32'h7);
        llop = 1'b0; scop = 1'b1;
        set_req(0, 1, 32'h80, 32'h11);
        step(0, 0, 32'h0, 0, 1, 0, 0, 32'h1);
        step(1, 0, 32'h0, 0, 1, 1, 0, 32'h1);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        scop = 1'b0;
        // invalidate in the same cycle as the LL completion wins
        llop = 1'b1; snoop_inv = 1'b1; snoop_addr = 32'h40;
        set_req(1, 0, 32'h40, 32'h0);
        step(1, 0, 32'h8, 1, 0, 1, 0, 32'h8);
        llop = 1'b0; snoop_inv = 1'b0; scop = 1'b1;
        set_req(0, 1, 32'h40, 32'h5);
        step(1, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        scop = 1'b0;
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
`endif

        // halt ignored while stalled, taken when pipe_en=1, then sticky with no strobes
        halt = 1'b1;
        step(0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
        halt = 1'b0;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        halt = 1'b1;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        halt = 1'b0;
        set_req(0, 1, 32'h600, 32'hAA);
        step(1, 0, 32'h0, 0, 0, 1, 1, 32'h0);
        set_req(1, 0, 32'h604, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 1, 32'h0);

        // reset clears halted
        set_req(0, 0, 32'h0, 32'h0);
        nRST = 1'b0;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        nRST = 1'b1;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        // reset in the middle of a miss: strobes drop without waiting for a clock
        set_req(1, 0, 32'h700, 32'h0);
        step(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
        nRST = 1'b0;
        #1;
        total++;
        if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_strobes got ren=%b wen=%b exp ren=0 wen=0", dmemREN, dmemWEN);
        end
        set_req(0, 0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        set_req(1, 0, 32'h708, 32'h0);
        step(1, 0, 32'h12, 1, 0, 1, 0, 32'h12);
        set_req(0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        @(negedge CLK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d entries left exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
